// File: rtl/hex_keypad_entry.sv
// -----------------------------------------------------------------------------
// hex_keypad_entry
//
// Scans a 4x4 hex keypad, debounces presses at full-scan granularity and shifts
// each accepted hex digit into a 16-bit operand register. The operand feeds the
// bfloat16 FMA datapath and is echoed on the seven-segment display.
//
// Ports:
//   clock_100Mhz  in   system clock
//   reset         in   asynchronous, active-high reset
//   row[3:0]      in   keypad rows, active low, pulled up, asynchronous
//   col[3:0]      out  keypad column drives, one-hot active low
//   clear         in   synchronous clear of value and digit_count
//   value[15:0]   out  entered operand, newest digit in [3:0]
//   key_code[3:0] out  hex code of the last accepted key
//   key_valid     out  one-cycle pulse per accepted press
//   key_held      out  high while a debounced key is held
//   digit_count   out  digits entered since reset/clear, saturates at 4
//
// Parameters:
//   SCAN_TICKS      cycles each column is driven low (minimum 4)
//   DEBOUNCE_SCANS  identical full scans needed for press/release (minimum 2)
// -----------------------------------------------------------------------------
module hex_keypad_entry #(
    parameter int SCAN_TICKS     = 100_000,
    parameter int DEBOUNCE_SCANS = 5
) (
    input  logic        clock_100Mhz,
    input  logic        reset,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    input  logic        clear,
    output logic [15:0] value,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [2:0]  digit_count
);

    localparam int TW = $clog2(SCAN_TICKS);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
    // The check compares the count before increment, so the last scan of a
    // debounce window is seen when cnt already equals DEBOUNCE_SCANS-1.
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_SCANS - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        PRESS_CHECK   = 2'd1,
        HELD          = 2'd2,
        RELEASE_CHECK = 2'd3
    } state_t;

    // Hex code for the key at row r, column c.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'b00_00: k = 4'h1;
            4'b00_01: k = 4'h2;
            4'b00_10: k = 4'h3;
            4'b00_11: k = 4'hA;
            4'b01_00: k = 4'h4;
            4'b01_01: k = 4'h5;
            4'b01_10: k = 4'h6;
            4'b01_11: k = 4'hB;
            4'b10_00: k = 4'h7;
            4'b10_01: k = 4'h8;
            4'b10_10: k = 4'h9;
            4'b10_11: k = 4'hC;
            4'b11_00: k = 4'h0;
            4'b11_01: k = 4'hF;
            4'b11_10: k = 4'hE;
            default:  k = 4'hD;
        endcase
        return k;
    endfunction

    // ---------------- stage p0/p1: row synchronizer ----------------
    logic [3:0] rs_p0;
    logic [3:0] rs;

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            rs_p0 <= 4'b1111;
            rs    <= 4'b1111;
        end else begin
            rs_p0 <= row;
            rs    <= rs_p0;
        end
    end

    // ---------------- column scan ----------------
    logic [TW-1:0] timer;
    logic [1:0]    col_idx;
    logic [3:0]    samp0;
    logic [3:0]    samp1;
    logic [3:0]    samp2;
    logic          tick;
    logic          scan_done;

    assign tick      = (timer == TICK_LAST);
    assign scan_done = tick && (col_idx == 2'd3);
    assign col       = ~(4'b0001 << col_idx);

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            timer   <= '0;
            col_idx <= 2'd0;
            samp0   <= 4'b1111;
            samp1   <= 4'b1111;
            samp2   <= 4'b1111;
        end else if (tick) begin
            timer   <= '0;
            col_idx <= col_idx + 2'd1;
            // Column 3 is not stored: it is consumed live in scan_done's cycle.
            case (col_idx)
                2'd0:    samp0 <= rs;
                2'd1:    samp1 <= rs;
                2'd2:    samp2 <= rs;
                default: ;
            endcase
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // ---------------- scan decode ----------------
    // low_cnt saturates at 2: anything beyond one low bit is MULTI.
    logic [3:0][3:0] scan_cols;
    logic [1:0]      low_cnt;
    logic [3:0]      hit_code;
    logic            scan_single;

    assign scan_cols = {rs, samp2, samp1, samp0};

    always_comb begin
        low_cnt  = 2'd0;
        hit_code = 4'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!scan_cols[c][r]) begin
                    if (low_cnt != 2'd2) begin
                        low_cnt = low_cnt + 2'd1;
                    end
                    hit_code = key_map(2'(r), 2'(c));
                end
            end
        end
    end

    assign scan_single = (low_cnt == 2'd1);

    // ---------------- debounce FSM ----------------
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [3:0]    cand;
    logic [3:0]    cand_nxt;
    logic          accept;

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            cand  <= 4'h0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            cand  <= cand_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cand_nxt  = cand;
        accept    = 1'b0;
        if (scan_done) begin
            case (state)
                IDLE: begin
                    if (scan_single) begin
                        cand_nxt  = hit_code;
                        cnt_nxt   = CNT_ONE;
                        state_nxt = PRESS_CHECK;
                    end
                end
                PRESS_CHECK: begin
                    if (scan_single && (hit_code == cand)) begin
                        if (cnt == CNT_LAST) begin
                            accept    = 1'b1;
                            state_nxt = HELD;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                HELD: begin
                    if (!scan_single) begin
                        cnt_nxt   = CNT_ONE;
                        state_nxt = RELEASE_CHECK;
                    end
                end
                RELEASE_CHECK: begin
                    // Any single key, even a different one, returns to HELD
                    // without an event: a key change needs a full release.
                    if (scan_single) begin
                        state_nxt = HELD;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign key_held = (state == HELD) || (state == RELEASE_CHECK);

    // ---------------- accept / operand register ----------------
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            key_valid   <= 1'b0;
            key_code    <= 4'h0;
            value       <= 16'h0000;
            digit_count <= 3'd0;
        end else begin
            key_valid <= accept;
            if (accept) begin
                key_code <= cand;
            end
            if (clear) begin
                // A digit accepted on the clear edge survives as the first digit.
                value       <= accept ? {12'h000, cand} : 16'h0000;
                digit_count <= accept ? 3'd1 : 3'd0;
            end else if (accept) begin
                value <= {value[11:0], cand};
                if (digit_count != 3'd4) begin
                    digit_count <= digit_count + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hex_keypad_entry.sv
module tb_hex_keypad_entry;

    localparam int SCAN_TICKS     = 4;
    localparam int DEBOUNCE_SCANS = 3;
    localparam int SCAN_CYC       = 4 * SCAN_TICKS;

    logic        clock_100Mhz = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] value;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [2:0]  digit_count;

    // Bit r*4+c set means the key at row r, column c is pressed.
    logic [15:0] pressed = 16'h0000;

    int checks = 0;
    int errors = 0;

    always #5 clock_100Mhz = ~clock_100Mhz;

    hex_keypad_entry #(
        .SCAN_TICKS    (SCAN_TICKS),
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) dut (
        .clock_100Mhz(clock_100Mhz),
        .reset       (reset),
        .row         (row),
        .col         (col),
        .clear       (clear),
        .value       (value),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_held    (key_held),
        .digit_count (digit_count)
    );

    // Keypad: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    logic [3:0] code_of [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC,
                                 4'h0, 4'hF, 4'hE, 4'hD};

    typedef struct packed {
        logic [3:0]  code;
        logic [15:0] val;
        logic [2:0]  cnt;
    } exp_t;

    exp_t sb[$];

    // Scan-level reference: runs of identical single-key scans while armed,
    // runs of empty/multi scans while disarmed.
    bit          armed;
    int          streak;
    int          rel;
    int          last_key;
    logic [15:0] m_value;
    int          m_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        armed    = 1'b1;
        streak   = 0;
        rel      = 0;
        last_key = -1;
        m_value  = 16'h0000;
        m_count  = 0;
        sb.delete();
    endtask

    task automatic model_scan(input logic [15:0] keys, input bit clr);
        int   res;
        bit   acc;
        exp_t e;
        res = -1;
        acc = 1'b0;
        if ($countones(keys) == 1) begin
            for (int i = 0; i < 16; i++) if (keys[i]) res = int'(code_of[i]);
        end
        if (armed) begin
            if (res < 0) begin
                streak = 0;
            end else if (streak > 0 && res != last_key) begin
                streak = 0;
            end else begin
                if (streak == 0) last_key = res;
                streak++;
                if (streak == DEBOUNCE_SCANS) begin
                    acc    = 1'b1;
                    armed  = 1'b0;
                    rel    = 0;
                    streak = 0;
                end
            end
        end else begin
            if (res < 0) begin
                rel++;
                if (rel == DEBOUNCE_SCANS) armed = 1'b1;
            end else begin
                rel = 0;
            end
        end
        if (acc) begin
            if (clr) begin
                m_value = {12'h000, 4'(last_key)};
                m_count = 1;
            end else begin
                m_value = {m_value[11:0], 4'(last_key)};
                m_count = (m_count < 4) ? m_count + 1 : 4;
            end
            e.code = 4'(last_key);
            e.val  = m_value;
            e.cnt  = 3'(m_count);
            sb.push_back(e);
        end else if (clr) begin
            m_value = 16'h0000;
            m_count = 0;
        end
    endtask

    // One full scan, starting at the negedge just after a scan boundary.
    task automatic do_scan(input logic [15:0] keys, input bit clr);
        logic [3:0] exp_col;
        pressed = keys;
        model_scan(keys, clr);
        for (int k = 0; k < SCAN_CYC; k++) begin
            exp_col = ~(4'b0001 << (k / SCAN_TICKS));
            chk("col", 32'(col), 32'(exp_col));
            if (k == SCAN_CYC - 1) clear = clr;
            @(negedge clock_100Mhz);
        end
        clear = 1'b0;
        chk("key_held", 32'(key_held), 32'(!armed));
    endtask

    task automatic press(input int idx, input int n_on, input int n_off);
        for (int i = 0; i < n_on; i++) do_scan(16'h0001 << idx, 1'b0);
        for (int i = 0; i < n_off; i++) do_scan(16'h0000, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock_100Mhz);
        chk("rst_col", 32'(col), 32'h0000000E);
        chk("rst_value", 32'(value), 32'h0);
        chk("rst_key_code", 32'(key_code), 32'h0);
        chk("rst_key_valid", 32'(key_valid), 32'h0);
        chk("rst_key_held", 32'(key_held), 32'h0);
        chk("rst_digit_count", 32'(digit_count), 32'h0);
        model_reset();
        reset = 1'b0;
    endtask

    // Scoreboard monitor: every key_valid cycle must match the oldest expectation.
    always @(negedge clock_100Mhz) begin
        if (!reset && key_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_key_valid: got key_code %0h value %0h, expected no event",
                         key_code, value);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ev_key_code", 32'(key_code), 32'(e.code));
                chk("ev_value", 32'(value), 32'(e.val));
                chk("ev_digit_count", 32'(digit_count), 32'(e.cnt));
            end
        end
    end

    logic [15:0] seq_exp [5] = '{16'h0001, 16'h0012, 16'h012A, 16'h12AF, 16'h2AF3};
    int          seq_idx [5] = '{0, 1, 3, 13, 2};

    initial begin
        model_reset();
        @(negedge clock_100Mhz);
        do_reset();

        // Idle: column walk, no events.
        do_scan(16'h0000, 1'b0);
        do_scan(16'h0000, 1'b0);
        chk("idle_value", 32'(value), 32'h0);

        // "6" held 5 scans, released 4.
        press(6, 5, 4);
        chk("six_value", 32'(value), 32'h0006);
        chk("six_count", 32'(digit_count), 32'd1);
        chk("six_code", 32'(key_code), 32'h6);

        // 1,2,A,F,3 from a cleared operand.
        do_scan(16'h0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            press(seq_idx[i], 3, 3);
            chk("seq_value", 32'(value), 32'(seq_exp[i]));
        end
        chk("seq_count_sat", 32'(digit_count), 32'd4);

        // Bounce on "9": never three consecutive scans.
        press(10, 2, 1);
        press(10, 2, 4);
        chk("bounce_value", 32'(value), 32'h2AF3);

        // "1" and "5" together, then "5" released.
        for (int i = 0; i < 4; i++) do_scan(16'h0021, 1'b0);
        chk("multi_value", 32'(value), 32'h2AF3);
        press(0, 3, 3);
        chk("multi_then_one", 32'(value), 32'hAF31);

        // value=1234, then clear coincident with the accept of "B".
        do_scan(16'h0000, 1'b1);
        press(0, 3, 3);
        press(1, 3, 3);
        press(2, 3, 3);
        press(4, 3, 3);
        chk("pre_clear_value", 32'(value), 32'h1234);
        do_scan(16'h0080, 1'b0);
        do_scan(16'h0080, 1'b0);
        do_scan(16'h0080, 1'b1);
        chk("clear_acc_value", 32'(value), 32'h000B);
        chk("clear_acc_count", 32'(digit_count), 32'd1);
        press(7, 0, 3);

        // Reset in PRESS_CHECK with "2" held; full debounce again afterwards.
        press(1, 2, 0);
        do_reset();
        press(1, 2, 0);
        chk("post_rst_value", 32'(value), 32'h0);
        chk("post_rst_held", 32'(key_held), 32'h0);
        press(1, 1, 3);
        chk("post_rst_accept", 32'(value), 32'h0002);

        // Random presses, occasional double keys and clears.
        for (int n = 0; n < 60; n++) begin
            logic [15:0] keys;
            int          on;
            int          off;
            keys = 16'h0001 << $urandom_range(15);
            if ($urandom_range(5) == 0) keys = keys | (16'h0001 << $urandom_range(15));
            on  = $urandom_range(5, 1);
            off = $urandom_range(4, 0);
            for (int i = 0; i < on; i++)  do_scan(keys, ($urandom_range(7) == 0));
            for (int i = 0; i < off; i++) do_scan(16'h0000, ($urandom_range(7) == 0));
        end
        press(0, 0, 4);

        repeat (2) @(negedge clock_100Mhz);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("final_value", 32'(value), 32'(m_value));
        chk("final_count", 32'(digit_count), 32'(m_count));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
